// File: rtl/ldm_stm_pkg.sv
// Shared types, constants and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LIST_W     = 16;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_e;

  // Addressing mode, encoded as {P, U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_e;

  // Instruction fields latched when an operation is accepted
  typedef struct packed {
    logic [LIST_W-1:0] list;
    logic              up;
    logic              pre;
    logic              load;
  } op_cfg_t;

  function automatic logic [CNT_W-1:0] popcount16(input logic [LIST_W-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(LIST_W); i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lowest_set_bit16.sv
// 16-to-4 priority encoder: index of the lowest set bit, plus a valid flag.
module lowest_set_bit16
  import ldm_stm_pkg::*;
(
  input  logic [LIST_W-1:0] i_vec,
  output logic [SEL_W-1:0]  o_idx,
  output logic              o_valid
);

  // Scan high to low so the lowest set bit is the last one to win
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = SEL_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list in ascending order, issuing one
// memory transfer per set bit. Base writeback is built only with LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [15:0]       i_reg_list,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_up,
  input  logic              i_pre,
  input  logic              i_load,
  input  logic              i_writeback,
  input  logic              i_mem_ready,
  output logic [3:0]        o_reg_sel,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_req,
  output logic              o_mem_write,
  output logic              o_reg_wr_en_c,
  output logic              o_base_wb_en,
  output logic [ADDR_W-1:0] o_base_wb_val,
  output logic              o_busy,
  output logic              o_done
);

  state_e            r_state;
  op_cfg_t           r_op;
  logic [ADDR_W-1:0] r_base;

  logic [LIST_W-1:0] w_mask_clr;
  logic [LIST_W-1:0] w_enc_in;
  logic [SEL_W-1:0]  w_lsb_idx;
  logic              w_lsb_valid;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_start_addr;
  mode_e             w_mode;

  // In XFER the encoder looks ahead to the mask with the current bit retired
  assign w_mask_clr = r_op.list & (r_op.list - LIST_W'(1));
  assign w_enc_in   = (r_state == ST_XFER) ? w_mask_clr : r_op.list;
  assign w_span     = ADDR_W'(popcount16(r_op.list)) * ADDR_W'(WORD_BYTES);
  assign w_mode     = mode_e'({r_op.pre, r_op.up});

  lowest_set_bit16 u_lsb (
    .i_vec   (w_enc_in),
    .o_idx   (w_lsb_idx),
    .o_valid (w_lsb_valid)
  );

  // Lowest transfer address; transfers always climb from here
  always_comb begin
    w_start_addr = r_base;
    case (w_mode)
      MODE_IA: w_start_addr = r_base;
      MODE_IB: w_start_addr = r_base + ADDR_W'(WORD_BYTES);
      MODE_DA: w_start_addr = r_base - w_span + ADDR_W'(WORD_BYTES);
      MODE_DB: w_start_addr = r_base - w_span;
      default: w_start_addr = r_base;
    endcase
  end

  assign o_reg_wr_en_c = o_mem_req & i_mem_ready & r_op.load;

`ifdef LDM_STM_WRITEBACK_EN
  logic              r_wb;
  logic [ADDR_W-1:0] r_wb_val;
  logic              r_base_wb_en;
  logic [ADDR_W-1:0] r_base_wb_val;
  logic [ADDR_W-1:0] w_wb_val;

  assign w_wb_val      = r_op.up ? (r_base + w_span) : (r_base - w_span);
  assign o_base_wb_en  = r_base_wb_en;
  assign o_base_wb_val = r_base_wb_val;
`else
  logic w_unused_wb;

  assign w_unused_wb   = i_writeback;
  assign o_base_wb_en  = 1'b0;
  assign o_base_wb_val = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_base      <= '0;
      o_reg_sel   <= '0;
      o_mem_addr  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_write <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
      r_wb          <= 1'b0;
      r_wb_val      <= '0;
      r_base_wb_en  <= 1'b0;
      r_base_wb_val <= '0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
      r_base_wb_en <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op.list <= i_reg_list;
            r_op.up   <= i_up;
            r_op.pre  <= i_pre;
            r_op.load <= i_load;
            r_base    <= i_base_addr;
`ifdef LDM_STM_WRITEBACK_EN
            r_wb      <= i_writeback;
`endif
            o_busy    <= 1'b1;
            r_state   <= ST_CALC;
          end
        end

        ST_CALC: begin
`ifdef LDM_STM_WRITEBACK_EN
          r_wb_val <= w_wb_val;
`endif
          if (w_lsb_valid) begin
            o_mem_req   <= 1'b1;
            o_mem_write <= ~r_op.load;
            o_reg_sel   <= w_lsb_idx;
            o_mem_addr  <= w_start_addr;
            r_state     <= ST_XFER;
          end else begin
            // Empty list: no transfers and no writeback
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_XFER: begin
          if (i_mem_ready) begin
            r_op.list <= w_mask_clr;
            if (w_lsb_valid) begin
              o_reg_sel  <= w_lsb_idx;
              o_mem_addr <= o_mem_addr + ADDR_W'(WORD_BYTES);
            end else begin
              o_mem_req   <= 1'b0;
              o_mem_write <= 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
              if (r_wb) begin
                r_base_wb_en  <= 1'b1;
                r_base_wb_val <= r_wb_val;
                r_state       <= ST_WB;
              end else begin
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
                r_state <= ST_DONE;
              end
`else
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= ST_DONE;
`endif
            end
          end
        end

`ifdef LDM_STM_WRITEBACK_EN
        ST_WB: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          r_state <= ST_DONE;
        end
`endif

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer against a transfer-list reference model.
module tb_ldm_stm_sequencer;

  localparam int unsigned ADDR_W = 32;
`ifdef LDM_STM_WRITEBACK_EN
  localparam bit WB_BUILD = 1'b1;
`else
  localparam bit WB_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              up, pre, load, writeback, mem_ready;
  logic [3:0]        reg_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req, mem_write, reg_wr_en;
  logic              base_wb_en;
  logic [ADDR_W-1:0] base_wb_val;
  logic              busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.ADDR_W(ADDR_W)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_reg_list    (reg_list),
    .i_base_addr   (base_addr),
    .i_up          (up),
    .i_pre         (pre),
    .i_load        (load),
    .i_writeback   (writeback),
    .i_mem_ready   (mem_ready),
    .o_reg_sel     (reg_sel),
    .o_mem_addr    (mem_addr),
    .o_mem_req     (mem_req),
    .o_mem_write   (mem_write),
    .o_reg_wr_en_c (reg_wr_en),
    .o_base_wb_en  (base_wb_en),
    .o_base_wb_val (base_wb_val),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic scramble_inputs();
    reg_list  = 16'($urandom);
    base_addr = $urandom;
    up        = 1'($urandom);
    pre       = 1'($urandom);
    load      = 1'($urandom);
    writeback = 1'($urandom);
  endtask

  // One operation. wmode: 0 always ready, 1 random waits, 2 first three XFER cycles wait.
  task automatic run_op(input logic [15:0] list, input logic [31:0] base,
                        input logic u, input logic p, input logic l, input logic w,
                        input int wmode, input bit noise);
    int            q_reg[$];
    logic [31:0]   q_addr[$];
    logic [31:0]   a, span, wbv;
    int            n, idx, forced, cyc;
    bit            wb_pending, in_xfer, is_wb, is_done, rdy;

    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    span = 32'(n) * 32'd4;
    case ({p, u})
      2'b01:   a = base;
      2'b11:   a = base + 32'd4;
      2'b00:   a = base - span + 32'd4;
      default: a = base - span;
    endcase
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        q_reg.push_back(i);
        q_addr.push_back(a);
        a = a + 32'd4;
      end
    end
    wbv        = u ? base + span : base - span;
    wb_pending = w && WB_BUILD && (n != 0);
    idx        = 0;
    forced     = 0;

    @(negedge clk);
    start = 1'b1; reg_list = list; base_addr = base;
    up = u; pre = p; load = l; writeback = w;
    mem_ready = 1'($urandom);

    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise) begin
        start = 1'($urandom);
        scramble_inputs();
      end
      in_xfer = (cyc >= 2) && (idx < n);
      is_wb   = (cyc >= 2) && (idx >= n) && wb_pending;
      is_done = (cyc >= 2) && (idx >= n) && !wb_pending;
      if (in_xfer && wmode == 2 && forced < 3) begin
        rdy = 1'b0;
        forced++;
      end else if (in_xfer && wmode == 0) rdy = 1'b1;
      else if (in_xfer) rdy = ($urandom_range(0, 99) >= 30);
      else rdy = 1'($urandom);
      mem_ready = rdy;
      #1;
      total++;
      if (mem_req !== in_xfer) begin
        bad++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, in_xfer);
      end
      total++;
      if (busy !== !is_done) begin
        bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !is_done);
      end
      total++;
      if (done !== is_done) begin
        bad++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, is_done);
      end
      total++;
      if (base_wb_en !== is_wb) begin
        bad++; $display("FAIL base_wb_en cyc=%0d got=%b exp=%b", cyc, base_wb_en, is_wb);
      end
      total++;
      if (reg_wr_en !== (in_xfer && l && rdy)) begin
        bad++; $display("FAIL reg_wr_en cyc=%0d got=%b exp=%b", cyc, reg_wr_en, in_xfer && l && rdy);
      end
      if (in_xfer) begin
        total++;
        if (reg_sel !== 4'(q_reg[idx])) begin
          bad++; $display("FAIL reg_sel cyc=%0d got=%0d exp=%0d", cyc, reg_sel, q_reg[idx]);
        end
        total++;
        if (mem_addr !== q_addr[idx]) begin
          bad++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, q_addr[idx]);
        end
        total++;
        if (mem_write !== !l) begin
          bad++; $display("FAIL mem_write cyc=%0d got=%b exp=%b", cyc, mem_write, !l);
        end
        if (rdy) idx++;
      end
      if (is_wb) begin
        total++;
        if (base_wb_val !== wbv) begin
          bad++; $display("FAIL base_wb_val got=%h exp=%h", base_wb_val, wbv);
        end
        wb_pending = 1'b0;
      end
      if (is_done) break;
    end
    if (cyc > 200) begin
      total++; bad++;
      $display("FAIL op_timeout got=no_done exp=done");
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({reg_sel, mem_addr, mem_req, mem_write, reg_wr_en, base_wb_en, base_wb_val, busy, done} !== '0) begin
      bad++;
      $display("FAIL %s got sel=%0d addr=%h req=%b wr=%b rwe=%b wbe=%b wbv=%h busy=%b done=%b exp=all_zero",
               tag, reg_sel, mem_addr, mem_req, mem_write, reg_wr_en, base_wb_en, base_wb_val, busy, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    scramble_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_all_zero("idle_ignores_ready");
  endtask

  task automatic test_ldm_ia();
    run_op(16'h8005, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stm_db();
    run_op(16'h4010, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_op(16'h0001, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_empty_list();
    run_op(16'h0000, 32'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stm_ib_full();
    run_op(16'hFFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_op(16'h0F0F, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    run_op(16'h8001, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; reg_list = 16'h00F0; base_addr = 32'h5000;
    up = 1'b1; pre = 1'b0; load = 1'b1; writeback = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_xfer");
    run_op(16'h0300, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(16'h0006, 32'h7000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h0180, 32'h7100, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if (k % 5 == 0) l = l & 16'($urandom);
      run_op(l, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    reg_list = '0; base_addr = '0; up = 1'b0; pre = 1'b0; load = 1'b0; writeback = 1'b0;
    test_reset();
    test_ldm_ia();
    test_stm_db();
    test_wait_states();
    test_empty_list();
    test_stm_ib_full();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Sequences ARM block data transfers (LDM/STM) over the 16-entry register file. Each cycle it walks the instruction's 16-bit register list in ascending order, drives the 4-bit register select (the S input of the register-file read mux for STM; the write address for LDM), and generates word addresses and memory handshakes. It also computes base-register writeback. It sits between the control unit and the register file/memory interface.

## Interface
- ADDR_W, 32, address and base-register width
- Clk  in  1  clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin operation; accepted only in IDLE
- RegList  in  16  bit i set = transfer Ri
- BaseAddr  in  ADDR_W  value of Rn
- Up  in  1  U bit: 1 increment, 0 decrement
- Pre  in  1  P bit: 1 before, 0 after
- Load  in  1  L bit: 1 LDM, 0 STM
- Writeback  in  1  W bit
- MemReady  in  1  memory completes the current transfer this cycle
- RegSel  out  4  register index of the current transfer
- MemAddr  out  ADDR_W  word address of the current transfer
- MemReq  out  1  transfer pending
- MemWrite  out  1  1 for STM while MemReq
- RegWrEn  out  1  LDM only: write memory data to RegSel; equals MemReq & MemReady & Load
- BaseWbEn  out  1  one-cycle writeback strobe
- BaseWbVal  out  ADDR_W  writeback value
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CALC, XFER, WB, DONE.
- IDLE: Start=1 captures RegList, BaseAddr, Up, Pre, Load and Writeback, then moves to CALC. Input changes after capture are ignored.
- CALC computes n = popcount(list) and the start address:
  - IA (U=1, P=0): Rn
  - IB (U=1, P=1): Rn+4
  - DA (U=0, P=0): Rn−4n+4
  - DB (U=0, P=1): Rn−4n
- CALC also computes the writeback value: Rn+4n if U, else Rn−4n. All arithmetic is mod 2^ADDR_W, with silent wrap.
- CALC exits to XFER if the list is nonzero; an empty list goes straight to DONE with no transfers and no writeback.
- XFER:
  - MemReq=1; RegSel = lowest set bit of the remaining mask; MemAddr = current address.
  - MemReady=1 clears that bit and adds 4 to the address.
  - MemReady=0 holds all outputs stable.
  - After the last bit completes, go to WB if Writeback, else DONE.
- Transfers always run in ascending register order at ascending addresses, regardless of U.
- WB: BaseWbEn=1 for one cycle with BaseWbVal, then DONE.
- DONE: Done=1 for one cycle, then IDLE. Start during DONE is ignored.
- MemReady outside XFER is ignored. Start outside IDLE is ignored.
- Reset at any point returns to IDLE and clears the mask.
- Reset values: all outputs 0 (RegSel=0, MemAddr=0, BaseWbVal=0, MemReq=0, BaseWbEn=0, Busy=0, Done=0).

## Timing
- Start sampled at cycle T; CALC at T+1; first MemReq at T+2.
- With MemReady held high, one transfer per cycle: XFER occupies T+2 … T+1+n.
- WB follows, then DONE. Done occurs at T+3+n with writeback, T+2+n without, and at T+2 for an empty list.
- Busy=1 from T+1 through the WB cycle; Busy=0 in DONE and IDLE.
- Each wait cycle (MemReady=0) extends XFER by one cycle.
- RegSel, MemAddr, MemReq, MemWrite, BaseWbEn, BaseWbVal, Busy and Done are registered. RegWrEn is combinational from MemReady.
- A Start in the cycle after DONE is accepted.

## Configuration
- LDM_STM_WRITEBACK_EN defined: WB state, BaseWbEn and BaseWbVal behave as above.
- Not defined:
  - Writeback input ignored; WB state and writeback adder removed.
  - BaseWbEn and BaseWbVal tied to 0.
  - Done at T+2+n.

## Structure
- Shared package ldm_stm_pkg holds:
  - state enumeration constants
  - WORD_BYTES=4
  - popcount16 function
  - addressing-mode encodings IA/IB/DA/DB
- One sub-module, lowest_set_bit16: combinational 16-to-4 priority encoder with a valid flag. Its output drives RegSel.

## Test plan
- LDM IA, RegList=16'h8005, Base=0x1000, W=1, MemReady=1 → RegSel 0,2,15 at addresses 0x1000/0x1004/0x1008 on T+2..T+4; RegWrEn each cycle; BaseWbVal=0x100C at T+5; Done at T+6.
- STM DB, RegList=16'h4010, Base=0x2000, W=1 → R4@0x1FF8, then R14@0x1FFC; MemWrite=1; RegWrEn=0; BaseWbVal=0x1FF8.
- LDM IA, RegList=16'h0001, MemReady low for 3 cycles → MemReq/RegSel=0/MemAddr held 3 cycles; completes on the 4th; Done 3 cycles later than zero-wait.
- RegList=16'h0000, W=1 → no MemReq, no BaseWbEn, Done at T+2.
- STM IB, RegList=16'hFFFF, Base=0x0, W=1 → 16 transfers R0..R15 at 0x4..0x40; BaseWbVal=0x40; Start pulses mid-operation ignored.
- Reset asserted in second XFER cycle → next cycle MemReq=0, Busy=0, all outputs 0; Start the following cycle begins a fresh operation.
